arm_mc_fsm: RTL and testbench

- Main control state machine for the multicycle ARM core: sequences the shared ALU, instruction/data memory port and register file across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Sits inside the multicycle controller beside the ALU decoder and condition logic.
- RegW/MemW/Branch are raw requests; condition logic gates them with CondEx downstream.
- Adds a memory-ready handshake for wait states and an instruction-retired counter.

---
 rtl/arm_mc_fsm.sv | 146 ++++++++++++++
 tb/tb_arm_mc_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_fsm.sv
// Main control FSM of the multicycle ARM core: sequences fetch, decode, execute,
// memory and write-back cycles, with a memory-ready wait handshake and a retired-instruction counter.
module arm_mc_fsm #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 MemReady,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 Branch,
  output logic                 ALUOp,
  output logic                 Illegal,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    Illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Gated by reset so no PC/IR write is requested while reset is held.
        IRWrite   = MemReady & reset;
        NextPC    = MemReady & reset;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    cnt_d = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_arm_mc_fsm.sv
// Directed bench for arm_mc_fsm: walks each instruction class cycle by cycle,
// checks the output signature per state, wait states, async reset and counter wrap.
module tb_arm_mc_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic        MemReady;

  logic        IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [31:0] InstrCount;

  logic        IRWrite4, AdrSrc4, ALUSrcA4, NextPC4, RegW4, MemW4, Branch4, ALUOp4, Illegal4;
  logic [1:0]  ALUSrcB4, ResultSrc4;
  logic [3:0]  InstrCount4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arm_mc_fsm #(.CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  arm_mc_fsm #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite4), .AdrSrc(AdrSrc4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
    .ResultSrc(ResultSrc4), .NextPC(NextPC4), .RegW(RegW4), .MemW(MemW4),
    .Branch(Branch4), .ALUOp(ALUOp4), .Illegal(Illegal4), .InstrCount(InstrCount4)
  );

  // Signature fields: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp Illegal
  localparam logic [12:0] SIG_FETCH1 = 13'b1_0_1_10_10_1_0_0_0_0_0;
  localparam logic [12:0] SIG_FETCH0 = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] SIG_DECODE = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] SIG_DECILL = 13'b0_0_1_10_10_0_0_0_0_0_1;
  localparam logic [12:0] SIG_MEMADR = 13'b0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [12:0] SIG_MEMRD  = 13'b0_1_0_00_00_0_0_0_0_0_0;
  localparam logic [12:0] SIG_MEMWB  = 13'b0_0_0_00_01_0_1_0_0_0_0;
  localparam logic [12:0] SIG_MEMWR  = 13'b0_1_0_00_00_0_0_1_0_0_0;
  localparam logic [12:0] SIG_EXECR  = 13'b0_0_0_00_00_0_0_0_0_1_0;
  localparam logic [12:0] SIG_EXECI  = 13'b0_0_0_01_00_0_0_0_0_1_0;
  localparam logic [12:0] SIG_ALUWB  = 13'b0_0_0_00_00_0_1_0_0_0_0;
  localparam logic [12:0] SIG_BRANCH = 13'b0_0_0_01_10_0_0_0_1_0_0;

  function automatic logic [12:0] sig();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
            RegW, MemW, Branch, ALUOp, Illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    MemReady = 1'b1;
    Op       = 2'b00;
    Funct    = 6'b000000;

    #3;
    check("reset_sig", 32'(sig()), 32'(SIG_FETCH0));
    check("reset_cnt", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("fetch_after_reset", 32'(sig()), 32'(SIG_FETCH1));

    // ADD immediate: FETCH, DECODE, EXECI, ALUWB
    Funct = 6'b101000;
    tick(); check("add_decode", 32'(sig()), 32'(SIG_DECODE));
    tick(); check("add_execi",  32'(sig()), 32'(SIG_EXECI));
    tick(); check("add_aluwb",  32'(sig()), 32'(SIG_ALUWB));
    check("add_cnt_before", InstrCount, 32'd0);
    tick(); check("add_fetch",  32'(sig()), 32'(SIG_FETCH1));
    check("add_cnt", InstrCount, 32'd1);

    // LDR with three wait cycles in MEMRD
    Op = 2'b01; Funct = 6'b011001;
    tick(); check("ldr_decode", 32'(sig()), 32'(SIG_DECODE));
    tick(); check("ldr_memadr", 32'(sig()), 32'(SIG_MEMADR));
    tick();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ldr_memrd_wait%0d", i), 32'(sig()), 32'(SIG_MEMRD));
      tick();
    end
    MemReady = 1'b1;
    #1;
    check("ldr_memrd_last", 32'(sig()), 32'(SIG_MEMRD));
    tick(); check("ldr_memwb", 32'(sig()), 32'(SIG_MEMWB));
    check("ldr_cnt_before", InstrCount, 32'd1);
    tick(); check("ldr_fetch", 32'(sig()), 32'(SIG_FETCH1));
    check("ldr_cnt", InstrCount, 32'd2);

    // STR with two wait cycles in MEMWR
    Funct = 6'b011000;
    tick(); check("str_decode", 32'(sig()), 32'(SIG_DECODE));
    tick(); check("str_memadr", 32'(sig()), 32'(SIG_MEMADR));
    tick();
    MemReady = 1'b0;
    #1;
    check("str_memwr0", 32'(sig()), 32'(SIG_MEMWR));
    tick(); check("str_memwr1", 32'(sig()), 32'(SIG_MEMWR));
    tick();
    MemReady = 1'b1;
    #1;
    check("str_memwr2", 32'(sig()), 32'(SIG_MEMWR));
    check("str_cnt_before", InstrCount, 32'd2);
    tick(); check("str_fetch", 32'(sig()), 32'(SIG_FETCH1));
    check("str_cnt", InstrCount, 32'd3);

    // Fetch wait state, then branch
    Op = 2'b10; Funct = 6'b000000;
    MemReady = 1'b0;
    #1;
    check("fetch_wait0", 32'(sig()), 32'(SIG_FETCH0));
    tick(); check("fetch_wait1", 32'(sig()), 32'(SIG_FETCH0));
    MemReady = 1'b1;
    #1;
    check("fetch_ready", 32'(sig()), 32'(SIG_FETCH1));
    tick(); check("br_decode", 32'(sig()), 32'(SIG_DECODE));
    tick(); check("br_branch", 32'(sig()), 32'(SIG_BRANCH));
    tick(); check("br_fetch",  32'(sig()), 32'(SIG_FETCH1));
    check("br_cnt", InstrCount, 32'd4);

    // Undefined Op: Illegal pulse in DECODE, no retire
    Op = 2'b11;
    tick(); check("ill_decode", 32'(sig()), 32'(SIG_DECILL));
    tick(); check("ill_fetch",  32'(sig()), 32'(SIG_FETCH1));
    check("ill_cnt", InstrCount, 32'd4);

    // Register data-processing: EXECR path
    Op = 2'b00; Funct = 6'b001000;
    tick(); check("dpr_decode", 32'(sig()), 32'(SIG_DECODE));
    tick(); check("dpr_execr",  32'(sig()), 32'(SIG_EXECR));
    tick(); check("dpr_aluwb",  32'(sig()), 32'(SIG_ALUWB));
    tick(); check("dpr_fetch",  32'(sig()), 32'(SIG_FETCH1));
    check("dpr_cnt", InstrCount, 32'd5);

    // Async reset in the middle of a store
    Op = 2'b01; Funct = 6'b011000;
    tick(); tick(); tick();
    MemReady = 1'b0;
    #1;
    check("rst_memwr_before", 32'(MemW), 32'd1);
    MemReady = 1'b1;
    reset    = 1'b0;
    #1;
    check("rst_memw_drop", 32'(MemW), 32'd0);
    check("rst_sig", 32'(sig()), 32'(SIG_FETCH0));
    check("rst_cnt", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_release_sig", 32'(sig()), 32'(SIG_FETCH1));
    check("rst_release_cnt", InstrCount, 32'd0);

    // Counter wrap on the 4-bit instance
    Op = 2'b00; Funct = 6'b101000;
    for (int i = 0; i < 15; i++) repeat (4) tick();
    check("wrap_cnt32_15", InstrCount, 32'd15);
    check("wrap_cnt4_15", 32'(InstrCount4), 32'd15);
    repeat (4) tick();
    check("wrap_cnt32_16", InstrCount, 32'd16);
    check("wrap_cnt4_0", 32'(InstrCount4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
